// File: rtl/upstream_cache_arbiter.sv
// upstream_cache_arbiter: round-robin share of the single-ported upstream risk cache
// between NREQ gateways, one transaction in flight at a time.
// Optional macro ARB_TIMEOUT_EN: abort a WAIT that lasts TIMEOUT cycles with resp_err=1.
module upstream_cache_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic                   cache_valid,
  output logic                   cache_rw,
  output logic [ADDR_W-1:0]      cache_addr,
  output logic [DATA_W-1:0]      cache_data,
  input  logic                   cache_ready,
  input  logic [DATA_W-1:0]      cache_rdata,
  output logic                   busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, g_q, gnt_idx;
  logic              gnt_any;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdata_q;
  logic              tmo;

  // Rotating priority: scan from rr_q downward in offset so the smallest offset wins last.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

  // WAIT cycle counter and abort flag; the flag is only meaningful in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
      err_q <= !cache_ready && tmo;
    end
  end

  assign resp_err = err_q && (state_q == RESP);
`else
  assign tmo      = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Next state and per-state strobes; grant/response pulses are suppressed while in reset.
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    resp_valid  = '0;
    cache_valid = 1'b0;
    case (state_q)
      IDLE:  if (gnt_any) begin
               req_ready[gnt_idx] = 1'b1;
               state_d            = ISSUE;
             end
      ISSUE: begin
               cache_valid = 1'b1;
               state_d     = WAIT;
             end
      WAIT:  begin
               cache_valid = 1'b1;
               if (cache_ready || tmo) state_d = RESP;
             end
      RESP:  begin
               resp_valid[g_q] = 1'b1;
               state_d         = IDLE;
             end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready  = '0;
      resp_valid = '0;
    end
  end

  // State, issue registers, read capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_any) begin
        g_q    <= gnt_idx;
        rw_q   <= req_rw[gnt_idx];
        addr_q <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        data_q <= req_data[gnt_idx*DATA_W +: DATA_W];
      end
      if (state_q == WAIT) begin
        if (cache_ready) rdata_q <= cache_rdata;
        else if (tmo)    rdata_q <= '0;
      end
      if (state_q == RESP) rr_q <= (g_q == LAST) ? '0 : g_q + 1'b1;
    end
  end

  assign cache_rw   = rw_q;
  assign cache_addr = addr_q;
  assign cache_data = data_q;
  assign resp_data  = rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_upstream_cache_arbiter.sv
// Directed bench for upstream_cache_arbiter (NREQ=4, 32-bit address/data).
module tb_upstream_cache_arbiter;
  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid, req_rw, req_ready, resp_valid;
  logic [NREQ*32-1:0] req_addr, req_data;
  logic [31:0]      resp_data, cache_addr, cache_data, cache_rdata;
  logic             resp_err, cache_valid, cache_rw, cache_ready, busy;

  logic [31:0] addr_m [NREQ];
  logic [31:0] data_m [NREQ];
  logic        rw_m   [NREQ];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*32 +: 32] = addr_m[i];
      req_data[i*32 +: 32] = data_m[i];
      req_rw[i]            = rw_m[i];
    end
  end

  upstream_cache_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .cache_valid(cache_valid), .cache_rw(cache_rw), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_ready(cache_ready), .cache_rdata(cache_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // One full transaction, entered at posedge+1 of the IDLE cycle with req_valid already set.
  // g: expected winner; n_low: WAIT cycles with ready low before the ready cycle.
  task automatic txn(input int g, input int n_low, input logic [31:0] rd, input bit drop);
    logic [3:0] oh;
    oh = 4'(1 << g);
    @(negedge clk);
    chk("gnt", 32'(req_ready), 32'(oh));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_resp", 32'(resp_valid), 0);
    nxt();
    if (drop) req_valid[g] = 1'b0;
    @(negedge clk);
    chk("iss_valid", 32'(cache_valid), 1);
    chk("iss_addr", cache_addr, addr_m[g]);
    chk("iss_rw", 32'(cache_rw), 32'(rw_m[g]));
    chk("iss_data", cache_data, data_m[g]);
    chk("iss_rdy", 32'(req_ready), 0);
    for (int i = 0; i < n_low; i++) begin
      nxt();
      @(negedge clk);
      chk("wait_valid", 32'(cache_valid), 1);
      chk("wait_addr", cache_addr, addr_m[g]);
      chk("wait_rw", 32'(cache_rw), 32'(rw_m[g]));
      chk("wait_data", cache_data, data_m[g]);
      chk("wait_resp", 32'(resp_valid), 0);
    end
    nxt();
    cache_ready = 1'b1;
    cache_rdata = rd;
    @(negedge clk);
    chk("rdy_valid", 32'(cache_valid), 1);
    chk("rdy_addr", cache_addr, addr_m[g]);
    nxt();
    cache_ready = 1'b0;
    cache_rdata = 32'h0;
    @(negedge clk);
    chk("resp_oh", 32'(resp_valid), 32'(oh));
    chk("resp_data", resp_data, rd);
    chk("resp_err", 32'(resp_err), 0);
    chk("resp_cvalid", 32'(cache_valid), 0);
    chk("resp_rdy", 32'(req_ready), 0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      addr_m[i] = 32'h100 + 32'(i);
      data_m[i] = 32'hA000_0000 + 32'(i);
      rw_m[i]   = 1'b0;
    end
    addr_m[0]   = 32'h15;
    rst         = 1'b1;
    req_valid   = 4'b1111;
    cache_ready = 1'b0;
    cache_rdata = 32'h0;

    // 1: reset held with all requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_cvalid", 32'(cache_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_resp", 32'(resp_valid), 0);
      nxt();
    end
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("post_rst_rdy", 32'(req_ready), 0);
    nxt();

    // 2: single read hit from requester 0, ready two cycles after issue
    req_valid = 4'b0001;
    txn(0, 1, 32'h00AB_0012, 1'b1);
    @(negedge clk);
    chk("t2_idle", 32'(busy), 0);
    nxt();

    // 3: all requesting from a fresh pointer -> 0,1,2,3,0
    rst = 1'b1;
    nxt();
    rst       = 1'b0;
    req_valid = 4'b1111;
    txn(0, 0, 32'h1111_0000, 1'b0);
    txn(1, 0, 32'h1111_0001, 1'b0);
    txn(2, 2, 32'h1111_0002, 1'b0);
    txn(3, 0, 32'h1111_0003, 1'b0);
    txn(0, 0, 32'h1111_0004, 1'b0);
    req_valid = 4'b0000;

    // 4: requester 2 write on a miss, ready on the 8th WAIT cycle
    rw_m[2]   = 1'b1;
    data_m[2] = 32'h0000_0010;
    addr_m[2] = 32'h0000_0042;
    req_valid = 4'b0100;
    txn(2, 7, 32'h0000_0077, 1'b1);
    @(negedge clk);
    chk("t4_single_resp", 32'(resp_valid), 0);
    nxt();
    rw_m[2] = 1'b0;

    // 5: reset while in WAIT drops the transaction and clears the pointer
    req_valid = 4'b0010;      // pointer is 3: wraps past 3,0 to reach 1
    @(negedge clk);
    chk("t5_gnt", 32'(req_ready), 32'h2);
    nxt();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_issue", 32'(cache_valid), 1);
    nxt();
    @(negedge clk);
    chk("t5_wait", 32'(cache_valid), 1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cvalid", 32'(cache_valid), 0);
    chk("t5_resp", 32'(resp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    nxt();
    @(negedge clk);
    chk("t5_noresp", 32'(resp_valid), 0);
    nxt();
    req_valid = 4'b1111;
    txn(0, 0, 32'h5555_0000, 1'b0);

    // 7: sparse requesters with wrap: pointer 1 -> 1, then 3, then wrap to 1
    req_valid = 4'b1010;
    txn(1, 0, 32'h7777_0001, 1'b0);
    txn(3, 1, 32'h7777_0003, 1'b0);
    txn(1, 0, 32'h7777_0011, 1'b0);
    req_valid = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // 6: cache never ready -> abort after 64 WAIT cycles, then normal grant to g+1
    begin
      int held;
      held      = 0;
      req_valid = 4'b1111;
      @(negedge clk);
      chk("t6_gnt", 32'(req_ready), 32'h4);
      nxt();
      req_valid = 4'b0000;
      @(negedge clk);
      chk("t6_issue", 32'(cache_valid), 1);
      for (int i = 0; i < 64; i++) begin
        nxt();
        @(negedge clk);
        if (cache_valid === 1'b1 && resp_valid === 4'b0) held++;
      end
      chk("t6_wait_cycles", 32'(held), 64);
      nxt();
      @(negedge clk);
      chk("t6_resp", 32'(resp_valid), 32'h4);
      chk("t6_err", 32'(resp_err), 1);
      chk("t6_data", resp_data, 0);
      nxt();
      req_valid = 4'b1111;
      txn(3, 0, 32'h6666_0003, 1'b0);
      req_valid = 4'b0000;
    end
`endif

    repeat (2) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
